// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue/capture controller between a requester and the 32-bit ALU.
// Holds opcode/operands stable for the op latency, then captures and returns the result.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_z,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] z_q, z_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;

  function automatic logic isLegal(input logic [4:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV: isLegal = 1'b1;
      default:                                         isLegal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Rejected requests never reach the ALU; they answer immediately with an error.
          if (!isLegal(req_opcode) || (req_opcode == OP_DIV && req_b == 32'd0)) begin
            z_d     = 32'd0;
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            opcode_d = req_opcode;
            a_d      = req_a;
            b_d      = req_b;
            if (req_opcode == OP_MUL)      cnt_d = MUL_LAST;
            else if (req_opcode == OP_DIV) cnt_d = DIV_LAST;
            else                           cnt_d = 8'd0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (opcode_q == OP_MUL || opcode_q == OP_DIV) begin
            z_d  = alu_lo;
            hi_d = alu_hi;
            lo_d = alu_lo;
          end else begin
            z_d  = alu_z;
            hi_d = 32'd0;
            lo_d = 32'd0;
          end
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      opcode_q <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      z_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = valid_q;
  assign rsp_z      = z_q;
  assign rsp_hi     = hi_q;
  assign rsp_lo     = lo_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } rsp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_z;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  rsp_t expQ[$];

  alu_op_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_z(alu_z), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Small behavioural ALU for the ops the directed vectors use.
  logic [63:0] product;
  always_comb begin
    product = 64'(alu_a) * 64'(alu_b);
    alu_z   = 32'd0;
    alu_hi  = 32'd0;
    alu_lo  = 32'd0;
    case (alu_opcode)
      5'b00011: alu_z = alu_a + alu_b;
      5'b00100: alu_z = alu_a - alu_b;
      5'b01010: alu_z = alu_a & alu_b;
      5'b01111: begin alu_hi = product[63:32]; alu_lo = product[31:0]; end
      5'b10000: if (alu_b != 32'd0) begin alu_lo = alu_a / alu_b; alu_hi = alu_a % alu_b; end
      default:  alu_z = 32'hDEAD_BEEF;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake consumes one scoreboard entry.
  always @(negedge clock) begin
    if (!clear && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got z=%h err=%b, expected no response", rsp_z, rsp_err);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_z", rsp_z, e.z);
        checkOutput("rsp_hi", rsp_hi, e.hi);
        checkOutput("rsp_lo", rsp_lo, e.lo);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Presents one request for one edge; returns #1 into the cycle after the accept edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit push, input rsp_t e);
    checkOutput("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    if (push) expQ.push_back(e);
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    req_opcode = 5'h1F;
    req_a      = 32'hFFFF_FFFF;
    req_b      = 32'hFFFF_FFFF;
  endtask

  // Counts cycles from T+1 until rsp_valid rises and checks it against 1+lat.
  task automatic waitResp(input int lat, input string name);
    int cyc;
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checkOutput(name, 32'(cyc), 32'(1 + lat));
  endtask

  task automatic finishHandshake();
    @(posedge clock);
    #1;
    checkOutput("idle_after_rsp", 32'(req_ready), 32'd1);
  endtask

  function automatic rsp_t mk(input logic [31:0] z, input logic [31:0] hi,
                              input logic [31:0] lo, input logic err);
    rsp_t r;
    r.z = z; r.hi = hi; r.lo = lo; r.err = err;
    return r;
  endfunction

  initial begin
    clear      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 5'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_alu_opcode", 32'(alu_opcode), 32'd0);

    // ADD 5+7
    applyStimulus(5'b00011, 32'd5, 32'd7, 1'b1, mk(32'd12, 32'd0, 32'd0, 1'b0));
    checkOutput("add_alu_opcode", 32'(alu_opcode), 32'b00011);
    checkOutput("add_busy", 32'(busy), 32'd1);
    waitResp(1, "add_latency");
    finishHandshake();

    // MUL 0x10000 * 0x10000 = 2^32
    applyStimulus(5'b01111, 32'h1_0000, 32'h1_0000, 1'b1, mk(32'd0, 32'd1, 32'd0, 1'b0));
    waitResp(4, "mul_latency");
    checkOutput("mul_alu_a_held", alu_a, 32'h1_0000);
    finishHandshake();

    // DIV by zero: error without touching the ALU registers
    applyStimulus(5'b10000, 32'd9, 32'd0, 1'b1, mk(32'd0, 32'd0, 32'd0, 1'b1));
    checkOutput("div0_alu_opcode_kept", 32'(alu_opcode), 32'b01111);
    checkOutput("div0_alu_b_kept", alu_b, 32'h1_0000);
    waitResp(0, "div0_latency");
    finishHandshake();

    // Illegal opcode, then ADD 1+1
    applyStimulus(5'b11111, 32'd3, 32'd4, 1'b1, mk(32'd0, 32'd0, 32'd0, 1'b1));
    waitResp(0, "illegal_latency");
    finishHandshake();
    applyStimulus(5'b00011, 32'd1, 32'd1, 1'b1, mk(32'd2, 32'd0, 32'd0, 1'b0));
    waitResp(1, "add2_latency");
    finishHandshake();

    // DIV 100/7 -> quotient 14, remainder 2
    applyStimulus(5'b10000, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 32'd14, 1'b0));
    waitResp(8, "div_latency");
    finishHandshake();

    // SUB 3-5 with back-pressure; a competing request must be ignored
    rsp_ready = 1'b0;
    applyStimulus(5'b00100, 32'd3, 32'd5, 1'b1, mk(32'hFFFF_FFFE, 32'd0, 32'd0, 1'b0));
    waitResp(1, "sub_latency");
    req_valid  = 1'b1;
    req_opcode = 5'b00011;
    req_a      = 32'd9;
    req_b      = 32'd9;
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_rsp_z", rsp_z, 32'hFFFF_FFFE);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    finishHandshake();
    checkOutput("bp_alu_opcode_kept", 32'(alu_opcode), 32'b00100);
    checkOutput("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);

    // DIV aborted by clear when the counter reaches 3
    applyStimulus(5'b10000, 32'd50, 32'd5, 1'b0, mk(32'd0, 32'd0, 32'd0, 1'b0));
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("clr_busy", 32'(busy), 32'd0);
    checkOutput("clr_req_ready", 32'(req_ready), 32'd1);
    checkOutput("clr_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("clr_alu_opcode", 32'(alu_opcode), 32'd0);
    checkOutput("clr_alu_a", alu_a, 32'd0);
    checkOutput("clr_alu_b", alu_b, 32'd0);
    checkOutput("clr_rsp_z", rsp_z, 32'd0);
    checkOutput("clr_rsp_hi", rsp_hi, 32'd0);
    checkOutput("clr_rsp_err", 32'(rsp_err), 32'd0);
    repeat (12) @(posedge clock);
    #1;
    checkOutput("clr_no_late_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
